// File: rtl/pll_sequencer_if.sv
// rtl/pll_sequencer_if.sv - PLL sequencer lock input, re-lock request and clock/reset control outputs
interface pll_sequencer_if;
    logic       locked;
    logic       request;
    logic       pll_rst;
    logic       clk_en;
    logic       sys_reset_n;
    logic       ready;
    logic [3:0] retries;

    modport master (
        output locked, request,
        input  pll_rst, clk_en, sys_reset_n, ready, retries
    );

    modport slave (
        input  locked, request,
        output pll_rst, clk_en, sys_reset_n, ready, retries
    );
endinterface

// File: rtl/pll_sequencer.sv
// rtl/pll_sequencer.sv - PLL reset/lock/clock-enable/core-reset sequencer on the free-running 50 MHz clock
module pll_sequencer #(
    parameter int RST_CYCLES      = 16,
    parameter int LOCK_FILTER     = 1024,
    parameter int RELEASE_STAGGER = 32,
    parameter int RETRY_TIMEOUT   = 65535
) (
    input  logic            clock50,
    input  logic            reset_n,
    pll_sequencer_if.slave  bus
);
    localparam int CNT_MAX_A = (RST_CYCLES > LOCK_FILTER) ? RST_CYCLES : LOCK_FILTER;
    localparam int CNT_MAX_B = (RELEASE_STAGGER > RETRY_TIMEOUT) ? RELEASE_STAGGER : RETRY_TIMEOUT;
    localparam int CNT_MAX   = (CNT_MAX_A > CNT_MAX_B) ? CNT_MAX_A : CNT_MAX_B;
    localparam int CW        = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] RST_LAST  = CW'(RST_CYCLES - 1);
    // The WAIT_LOCK cycle that first sees lock is the first of the LOCK_FILTER samples.
    localparam logic [CW-1:0] FILT_LAST = CW'((LOCK_FILTER >= 2) ? LOCK_FILTER - 2 : 0);
    localparam logic [CW-1:0] STAG_LAST = CW'((RELEASE_STAGGER >= 1) ? RELEASE_STAGGER - 1 : 0);
    localparam logic [CW-1:0] TMO_LAST  = CW'(RETRY_TIMEOUT);

    typedef enum logic [2:0] {
        S_RESET_PLL,
        S_WAIT_LOCK,
        S_FILTER,
        S_ENABLE,
        S_RUN
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_lock_meta;
    logic          r_locked_s;
    logic          r_pll_rst;
    logic          r_clk_en;
    logic          r_sys_reset_n;
    logic          r_ready;
    logic [3:0]    r_retries;

    always_ff @(posedge clock50 or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_RESET_PLL;
            r_cnt         <= '0;
            r_lock_meta   <= 1'b0;
            r_locked_s    <= 1'b0;
            r_pll_rst     <= 1'b1;
            r_clk_en      <= 1'b0;
            r_sys_reset_n <= 1'b0;
            r_ready       <= 1'b0;
            r_retries     <= 4'd0;
        end else begin
            r_lock_meta <= bus.locked;
            r_locked_s  <= r_lock_meta;
            r_cnt       <= r_cnt + 1'b1;

            case (r_state)
                S_RESET_PLL: begin
                    if (r_cnt == RST_LAST) begin
                        r_state   <= S_WAIT_LOCK;
                        r_cnt     <= '0;
                        r_pll_rst <= 1'b0;
                    end
                end
                S_WAIT_LOCK: begin
                    if (r_locked_s) begin
                        r_state <= S_FILTER;
                        r_cnt   <= '0;
                    end else if (r_cnt == TMO_LAST) begin
                        r_state   <= S_RESET_PLL;
                        r_cnt     <= '0;
                        r_pll_rst <= 1'b1;
                        if (r_retries != 4'hF) begin
                            r_retries <= r_retries + 4'd1;
                        end
                    end
                end
                S_FILTER: begin
                    if (!r_locked_s) begin
                        r_state <= S_WAIT_LOCK;
                        r_cnt   <= '0;
                    end else if (r_cnt == FILT_LAST) begin
                        r_state  <= S_ENABLE;
                        r_cnt    <= '0;
                        r_clk_en <= 1'b1;
                    end
                end
                S_ENABLE: begin
                    if (!r_locked_s) begin
                        r_state   <= S_RESET_PLL;
                        r_cnt     <= '0;
                        r_pll_rst <= 1'b1;
                        r_clk_en  <= 1'b0;
                    end else if (r_cnt == STAG_LAST) begin
                        r_state       <= S_RUN;
                        r_cnt         <= '0;
                        r_sys_reset_n <= 1'b1;
                        r_ready       <= 1'b1;
                    end
                end
                S_RUN: begin
                    // Shutdown drops everything on one edge; a lock loss is not a timeout.
                    if (!r_locked_s || bus.request) begin
                        r_state       <= S_RESET_PLL;
                        r_cnt         <= '0;
                        r_pll_rst     <= 1'b1;
                        r_clk_en      <= 1'b0;
                        r_sys_reset_n <= 1'b0;
                        r_ready       <= 1'b0;
                    end
                end
                default: begin
                    r_state       <= S_RESET_PLL;
                    r_cnt         <= '0;
                    r_pll_rst     <= 1'b1;
                    r_clk_en      <= 1'b0;
                    r_sys_reset_n <= 1'b0;
                    r_ready       <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pll_rst     = r_pll_rst;
    assign bus.clk_en      = r_clk_en;
    assign bus.sys_reset_n = r_sys_reset_n;
    assign bus.ready       = r_ready;
    assign bus.retries     = r_retries;
endmodule
